// File: rtl/video_timing.sv
// Raster timing generator: free-running pixel/line counters decoded into registered hpos/vpos,
// de, syncs and frame/line strobes. Define VIDEO_TIMING_FRAME_CNT_EN to add the frame_cnt output.
module video_timing #(
  parameter int unsigned HRES      = 1280,
  parameter int unsigned VRES      = 720,
  parameter int unsigned H_FP      = 110,
  parameter int unsigned H_SYNC    = 40,
  parameter int unsigned H_BP      = 220,
  parameter int unsigned V_FP      = 5,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 20,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  output logic signed [11:0] hpos,
  output logic signed [11:0] vpos,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               fsync,
  output logic               lsync
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]        frame_cnt
`endif
);

  localparam int unsigned HTOTAL = HRES + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTOTAL = VRES + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_BEG = HRES + H_FP;
  localparam int unsigned HS_END = HRES + H_FP + H_SYNC;
  localparam int unsigned VS_BEG = VRES + V_FP;
  localparam int unsigned VS_END = VRES + V_FP + V_SYNC;

  if (HTOTAL > 2047) begin : g_htotal_chk
    $error("video_timing: HTOTAL exceeds 2047");
  end
  if (VTOTAL > 2047) begin : g_vtotal_chk
    $error("video_timing: VTOTAL exceeds 2047");
  end

  logic [10:0] hc_q, hc_d;
  logic [10:0] vc_q, vc_d;

  logic signed [11:0] hpos_q, vpos_q;
  logic de_q, hsync_q, vsync_q, fsync_q, lsync_q;
  logic de_d, hsync_d, vsync_d, fsync_d, lsync_d;

  always_comb begin
    hc_d = hc_q + 11'd1;
    vc_d = vc_q;
    if (hc_q == 11'(HTOTAL - 1)) begin
      hc_d = 11'd0;
      vc_d = (vc_q == 11'(VTOTAL - 1)) ? 11'd0 : vc_q + 11'd1;
    end
  end

  // Output decode of the current (hc, vc); registered below for one-cycle latency.
  always_comb begin
    de_d    = (hc_q < 11'(HRES)) && (vc_q < 11'(VRES));
    hsync_d = ((hc_q >= 11'(HS_BEG)) && (hc_q < 11'(HS_END))) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((vc_q >= 11'(VS_BEG)) && (vc_q < 11'(VS_END))) ? VSYNC_POL : ~VSYNC_POL;
    lsync_d = (hc_q == 11'd0);
    fsync_d = (hc_q == 11'd0) && (vc_q == 11'(VRES));
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      hc_q    <= 11'd0;
      vc_q    <= 11'd0;
      hpos_q  <= 12'sd0;
      vpos_q  <= 12'sd0;
      de_q    <= 1'b0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      fsync_q <= 1'b0;
      lsync_q <= 1'b0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hpos_q  <= signed'({1'b0, hc_q});
      vpos_q  <= signed'({1'b0, vc_q});
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fsync_q <= fsync_d;
      lsync_q <= lsync_d;
    end
  end

  assign hpos  = hpos_q;
  assign vpos  = vpos_q;
  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign fsync = fsync_q;
  assign lsync = lsync_q;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Counts alongside the registered fsync so the new value appears with the pulse.
  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      frame_cnt_q <= 16'd0;
    end else if (fsync_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing using a reduced raster; expected outputs come from a
// position-in-frame model (cycles since reset release modulo the frame length).
module tb_video_timing;

  localparam int H    = 16;
  localparam int HFP  = 3;
  localparam int HS   = 4;
  localparam int HBP  = 5;
  localparam int V    = 6;
  localparam int VFP  = 2;
  localparam int VS   = 2;
  localparam int VBP  = 3;
  localparam bit HPOL = 1'b0;
  localparam bit VPOL = 1'b1;
  localparam int HT   = H + HFP + HS + HBP;
  localparam int VT   = V + VFP + VS + VBP;
  localparam int FT   = HT * VT;

  localparam logic [28:0] RST_VEC = {24'd0, 1'b0, ~HPOL, ~VPOL, 1'b0, 1'b0};

  logic               clk;
  logic               rst_n;
  logic signed [11:0] hpos, vpos;
  logic               de, hsync, vsync, fsync, lsync;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
  logic [15:0]        frame_cnt;
`endif

  video_timing #(
    .HRES     (H),
    .VRES     (V),
    .H_FP     (HFP),
    .H_SYNC   (HS),
    .H_BP     (HBP),
    .V_FP     (VFP),
    .V_SYNC   (VS),
    .V_BP     (VBP),
    .HSYNC_POL(HPOL),
    .VSYNC_POL(VPOL)
  ) dut (
    .pixel_clk(clk),
    .rst_n    (rst_n),
    .hpos     (hpos),
    .vpos     (vpos),
    .de       (de),
    .hsync    (hsync),
    .vsync    (vsync),
    .fsync    (fsync),
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .lsync    (lsync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          k      = 0;
  int          exp_h, exp_vp;
  logic [28:0] exp_vec;
  logic [15:0] exp_fc = 16'd0;

  function automatic logic [28:0] model(int h, int v);
    logic hs_a, vs_a;
    hs_a = (h >= H + HFP) && (h < H + HFP + HS);
    vs_a = (v >= V + VFP) && (v < V + VFP + VS);
    return {12'(h), 12'(v), (h < H) && (v < V), hs_a ? HPOL : ~HPOL, vs_a ? VPOL : ~VPOL,
            (h == 0) && (v == V), h == 0};
  endfunction

  function automatic logic [28:0] obs();
    return {hpos, vpos, de, hsync, vsync, fsync, lsync};
  endfunction

  // Advance one clock and update the model from the rst_n value seen at that edge.
  task automatic step();
    bit r;
    int p;
    r = rst_n;
    @(posedge clk);
    #1;
    if (!r) begin
      exp_vec = RST_VEC;
      exp_h   = 0;
      exp_vp  = 0;
      k       = 0;
      exp_fc  = 16'd0;
    end else begin
      p       = k % FT;
      exp_h   = p % HT;
      exp_vp  = p / HT;
      exp_vec = model(exp_h, exp_vp);
      k++;
      if (exp_vec[1]) exp_fc = exp_fc + 16'd1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL reset_hold: got %h want %h", obs(), exp_vec);
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (!(hpos === 12'sd0 && vpos === 12'sd0 && de === 1'b1 && lsync === 1'b1)) begin
      errors++;
      $display("FAIL reset_release_first: got hpos=%0d vpos=%0d de=%b lsync=%b want 0 0 1 1",
               hpos, vpos, de, lsync);
    end
    step();
    checks++;
    if (!(hpos === 12'sd1 && lsync === 1'b0)) begin
      errors++;
      $display("FAIL reset_release_second: got hpos=%0d lsync=%b want 1 0", hpos, lsync);
    end
  endtask

  task automatic test_line();
    int de_cnt = 0, hs_cnt = 0, hs_first = -1, hs_last = -1;
    int ls_idx[$];
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < HT + 1; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL line_cycle: got %h want %h", obs(), exp_vec);
      end
      if (i < HT) begin
        if (de === 1'b1) de_cnt++;
        if (hsync === HPOL) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = int'(hpos);
          hs_last = int'(hpos);
        end
      end
      if (lsync === 1'b1) ls_idx.push_back(i);
    end
    checks++;
    if (de_cnt != H) begin
      errors++;
      $display("FAIL line_de_count: got %0d want %0d", de_cnt, H);
    end
    checks++;
    if (hs_cnt != HS || hs_first != H + HFP || hs_last != H + HFP + HS - 1) begin
      errors++;
      $display("FAIL line_hsync: got n=%0d %0d..%0d want n=%0d %0d..%0d", hs_cnt, hs_first,
               hs_last, HS, H + HFP, H + HFP + HS - 1);
    end
    checks++;
    if (ls_idx.size() != 2 || (ls_idx.size() == 2 && ls_idx[1] - ls_idx[0] != HT)) begin
      errors++;
      $display("FAIL line_lsync_period: got %0d pulses want 2 spaced %0d", ls_idx.size(), HT);
    end
  endtask

  task automatic test_frames();
    int fs_idx[$];
    int vs_cnt = 0, vs_min = 4096, vs_max = -1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FT; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL frame_cycle: got %h want %h", obs(), exp_vec);
      end
      if (fsync === 1'b1) begin
        fs_idx.push_back(i);
        checks++;
        if (hpos !== 12'sd0 || vpos !== 12'(V)) begin
          errors++;
          $display("FAIL frame_fsync_pos: got (%0d,%0d) want (0,%0d)", hpos, vpos, V);
        end
      end
      if (vsync === VPOL) begin
        vs_cnt++;
        if (int'(vpos) < vs_min) vs_min = int'(vpos);
        if (int'(vpos) > vs_max) vs_max = int'(vpos);
      end
    end
    checks++;
    if (fs_idx.size() != 2 || (fs_idx.size() == 2 && fs_idx[1] - fs_idx[0] != FT)) begin
      errors++;
      $display("FAIL frame_fsync_spacing: got %0d pulses want 2 spaced %0d", fs_idx.size(), FT);
    end
    checks++;
    if (vs_cnt != 2 * VS * HT || vs_min != V + VFP || vs_max != V + VFP + VS - 1) begin
      errors++;
      $display("FAIL frame_vsync: got n=%0d %0d..%0d want n=%0d %0d..%0d", vs_cnt, vs_min,
               vs_max, 2 * VS * HT, V + VFP, V + VFP + VS - 1);
    end
  endtask

  task automatic test_frame_wrap();
    int  n     = 0;
    bit  found = 0;
    while (n < FT + 2 && !found) begin
      step();
      n++;
      if (exp_h == HT - 1 && exp_vp == VT - 1) found = 1;
    end
    checks++;
    if (!found || hpos !== 12'(HT - 1) || vpos !== 12'(VT - 1)) begin
      errors++;
      $display("FAIL wrap_last: got (%0d,%0d) want (%0d,%0d)", hpos, vpos, HT - 1, VT - 1);
    end
    step();
    checks++;
    if (hpos !== 12'sd0 || vpos !== 12'sd0 || de !== 1'b1) begin
      errors++;
      $display("FAIL wrap_first: got (%0d,%0d) de=%b want (0,0) de=1", hpos, vpos, de);
    end
  endtask

  task automatic test_mid_reset();
    int  n     = 0;
    bit  found = 0;
    while (n < FT + 2 && !found) begin
      step();
      n++;
      if (exp_h == 10 && exp_vp == 3) found = 1;
    end
    checks++;
    if (!found || obs() !== exp_vec) begin
      errors++;
      $display("FAIL midrst_locate: got %h want %h", obs(), exp_vec);
    end
    rst_n = 1'b0;
    repeat (3) begin
      step();
      checks++;
      if (obs() !== RST_VEC) begin
        errors++;
        $display("FAIL midrst_hold: got %h want %h", obs(), RST_VEC);
      end
    end
    rst_n = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if (obs() !== exp_vec) begin
        errors++;
        $display("FAIL midrst_restart: got %h want %h", obs(), exp_vec);
      end
    end
  endtask

  task automatic test_random_reset();
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(1, 2 * FT)) begin
        step();
        checks++;
        if (obs() !== exp_vec) begin
          errors++;
          $display("FAIL rand_run: iter %0d got %h want %h", it, obs(), exp_vec);
        end
      end
      rst_n = 1'b0;
      repeat ($urandom_range(1, 4)) begin
        step();
        checks++;
        if (obs() !== exp_vec) begin
          errors++;
          $display("FAIL rand_rst: iter %0d got %h want %h", it, obs(), exp_vec);
        end
      end
      rst_n = 1'b1;
    end
  endtask

`ifdef VIDEO_TIMING_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int          pulses = 0;
    int          n      = 0;
    logic [15:0] want;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3 * FT; i++) begin
      step();
      checks++;
      if (frame_cnt !== exp_fc) begin
        errors++;
        $display("FAIL fcnt_track: got %0d want %0d", frame_cnt, exp_fc);
      end
      if (fsync === 1'b1) begin
        pulses++;
        want = 16'(pulses);
        checks++;
        if (frame_cnt !== want) begin
          errors++;
          $display("FAIL fcnt_at_fsync: got %0d want %0d", frame_cnt, want);
        end
      end
    end
    dut.frame_cnt_q = 16'hFFFF;
    exp_fc          = 16'hFFFF;
    step();
    while (n < FT + 2 && fsync !== 1'b1) begin
      step();
      n++;
    end
    checks++;
    if (fsync !== 1'b1 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL fcnt_wrap: got fsync=%b cnt=%0d want 1 0", fsync, frame_cnt);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_line();
    test_frames();
    test_frame_wrap();
    test_mid_reset();
    test_random_reset();
`ifdef VIDEO_TIMING_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
